// File: rtl/snake_step_ctrl.sv
// Snake movement sequencer: divides the clock into game steps, filters 180-degree
// reversals, advances the head one cell per step and ends the game on a wall hit.
module snake_step_ctrl #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int TICK_DIV = 5_000_000,
  parameter int XW       = 5,
  parameter int YW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic [1:0]    dir_req,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    cur_dir,
  output logic          step,
  output logic          game_over,
  output logic          running,
  output logic [15:0]   step_cnt
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_tick;
  logic [XW-1:0]   r_hx;
  logic [YW-1:0]   r_hy;
  logic [1:0]      r_dir;
  logic            r_step;
  logic [15:0]     r_cnt;

  logic            w_opp;
  logic [1:0]      w_nd;
  logic            w_tick_end;
  logic            w_step_ev;
  logic            w_wall;
  logic            w_init;

  // A request for the exact opposite direction keeps the current heading.
  always_comb begin
    w_opp      = (dir_req[1] == r_dir[1]) && (dir_req[0] != r_dir[0]);
    w_nd       = w_opp ? r_dir : dir_req;
    w_tick_end = (r_tick == CW'(TICK_DIV - 1));
    w_step_ev  = (r_state == S_RUN) && !pause && w_tick_end;
    w_init     = ((r_state == S_IDLE) || (r_state == S_OVER)) && start;
    w_wall     = 1'b0;
    case (w_nd)
      DIR_UP:    w_wall = (r_hy == '0);
      DIR_DOWN:  w_wall = (r_hy == YW'(GRID_H - 1));
      DIR_RIGHT: w_wall = (r_hx == XW'(GRID_W - 1));
      DIR_LEFT:  w_wall = (r_hx == '0);
      default:   w_wall = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_step_ev && w_wall) w_state_nxt = S_OVER;
      S_OVER:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
      r_hx   <= '0;
      r_hy   <= '0;
      r_dir  <= DIR_UP;
      r_step <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_step <= 1'b0;
      if (w_init) begin
        r_tick <= '0;
        r_hx   <= XW'(GRID_W / 2);
        r_hy   <= YW'(GRID_H / 2);
        r_dir  <= DIR_UP;
        r_cnt  <= '0;
      end else if (r_state == S_RUN && !pause) begin
        if (!w_tick_end) begin
          r_tick <= r_tick + CW'(1);
        end else begin
          r_tick <= '0;
          // Wall check precedes the move, so coordinates never wrap.
          if (!w_wall) begin
            r_dir  <= w_nd;
            r_step <= 1'b1;
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            case (w_nd)
              DIR_UP:    r_hy <= r_hy - YW'(1);
              DIR_DOWN:  r_hy <= r_hy + YW'(1);
              DIR_RIGHT: r_hx <= r_hx + XW'(1);
              default:   r_hx <= r_hx - XW'(1);
            endcase
          end
        end
      end
    end
  end

  assign head_x    = r_hx;
  assign head_y    = r_hy;
  assign cur_dir   = r_dir;
  assign step      = r_step;
  assign step_cnt  = r_cnt;
  assign game_over = (r_state == S_OVER);
  assign running   = (r_state == S_RUN);

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl on an 8x8 grid with a 4-cycle step period.
module tb_snake_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  dir_req = 2'b00;
  logic [2:0]  head_x;
  logic [2:0]  head_y;
  logic [1:0]  cur_dir;
  logic        step;
  logic        game_over;
  logic        running;
  logic [15:0] step_cnt;

  int n_vec = 0;
  int n_err = 0;

  snake_step_ctrl #(
    .GRID_W(8), .GRID_H(8), .TICK_DIV(4), .XW(3), .YW(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_req(dir_req),
    .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir), .step(step),
    .game_over(game_over), .running(running), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++; if ({head_x, head_y} !== 6'd0) begin n_err++; $display("FAIL reset_head: got (%0d,%0d) expected (0,0)", head_x, head_y); end
    n_vec++; if ({cur_dir, step, game_over, running} !== 5'd0) begin n_err++; $display("FAIL reset_ctrl: dir/step/over/run=%b expected 00000", {cur_dir, step, game_over, running}); end
    n_vec++; if (step_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", step_cnt); end
    rst = 1'b0;
    tick();
    n_vec++; if (running !== 1'b0) begin n_err++; $display("FAIL idle_hold: running=%0b expected 0", running); end
  endtask

  task automatic test_start_right_to_wall();
    logic [2:0] ex;
    dir_req = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if ({running, game_over} !== 2'b10) begin n_err++; $display("FAIL t1_entry_state: run/over=%b expected 10", {running, game_over}); end
    n_vec++; if ({head_x, head_y, cur_dir} !== {3'd4, 3'd4, 2'b00}) begin n_err++; $display("FAIL t1_entry_head: got (%0d,%0d) dir %b expected (4,4) dir 00", head_x, head_y, cur_dir); end
    for (int s = 1; s <= 3; s++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL t1_early_step: step=1 at step %0d cycle %0d expected 0", s, c); end
      end
      tick();
      ex = 3'(4 + s);
      n_vec++; if (step !== 1'b1) begin n_err++; $display("FAIL t1_step: step=%0b expected 1 at step %0d", step, s); end
      n_vec++; if ({head_x, head_y, cur_dir} !== {ex, 3'd4, 2'b10}) begin n_err++; $display("FAIL t1_head: got (%0d,%0d) dir %b expected (%0d,4) dir 10", head_x, head_y, cur_dir, ex); end
      n_vec++; if (step_cnt !== 16'(s)) begin n_err++; $display("FAIL t1_cnt: got %0d expected %0d", step_cnt, s); end
    end
    repeat (4) tick();
    n_vec++; if ({game_over, running, step} !== 3'b100) begin n_err++; $display("FAIL t1_wall: over/run/step=%b expected 100", {game_over, running, step}); end
    n_vec++; if ({head_x, head_y} !== {3'd7, 3'd4} || step_cnt !== 16'd3) begin n_err++; $display("FAIL t1_frozen: got (%0d,%0d) cnt %0d expected (7,4) cnt 3", head_x, head_y, step_cnt); end
    repeat (3) tick();
    n_vec++; if ({game_over, head_x} !== {1'b1, 3'd7}) begin n_err++; $display("FAIL t1_over_hold: over=%0b x=%0d expected 1,7", game_over, head_x); end
  endtask

  task automatic test_restart_from_over();
    dir_req = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_vec++; if ({running, game_over} !== 2'b10) begin n_err++; $display("FAIL t5_state: run/over=%b expected 10", {running, game_over}); end
    n_vec++; if ({head_x, head_y, cur_dir} !== {3'd4, 3'd4, 2'b00}) begin n_err++; $display("FAIL t5_head: got (%0d,%0d) dir %b expected (4,4) dir 00", head_x, head_y, cur_dir); end
    n_vec++; if (step_cnt !== 16'd0) begin n_err++; $display("FAIL t5_cnt: got %0d expected 0", step_cnt); end
  endtask

  task automatic test_up_to_wall();
    logic [2:0] ey;
    dir_req = 2'b00;
    for (int s = 1; s <= 4; s++) begin
      repeat (3) tick();
      n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL t3_early_step: step=1 before step %0d expected 0", s); end
      tick();
      ey = 3'(4 - s);
      n_vec++; if ({step, head_x, head_y, cur_dir} !== {1'b1, 3'd4, ey, 2'b00}) begin n_err++; $display("FAIL t3_step: step=%0b (%0d,%0d) dir %b expected 1 (4,%0d) dir 00", step, head_x, head_y, cur_dir, ey); end
    end
    repeat (4) tick();
    n_vec++; if ({game_over, step} !== 2'b10) begin n_err++; $display("FAIL t3_wall: over/step=%b expected 10", {game_over, step}); end
    n_vec++; if ({head_x, head_y} !== {3'd4, 3'd0} || step_cnt !== 16'd4) begin n_err++; $display("FAIL t3_frozen: got (%0d,%0d) cnt %0d expected (4,0) cnt 4", head_x, head_y, step_cnt); end
  endtask

  task automatic test_reversal();
    dir_req = 2'b10;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_vec++; if ({step, head_x, head_y, cur_dir} !== {1'b1, 3'd5, 3'd4, 2'b10}) begin n_err++; $display("FAIL t2_first: step=%0b (%0d,%0d) dir %b expected 1 (5,4) dir 10", step, head_x, head_y, cur_dir); end
    dir_req = 2'b11;
    repeat (4) tick();
    n_vec++; if ({step, head_x, head_y, cur_dir} !== {1'b1, 3'd6, 3'd4, 2'b10}) begin n_err++; $display("FAIL t2_reject: step=%0b (%0d,%0d) dir %b expected 1 (6,4) dir 10", step, head_x, head_y, cur_dir); end
    dir_req = 2'b00;
    repeat (4) tick();
    n_vec++; if ({step, head_x, head_y, cur_dir} !== {1'b1, 3'd6, 3'd3, 2'b00}) begin n_err++; $display("FAIL t2_turn: step=%0b (%0d,%0d) dir %b expected 1 (6,3) dir 00", step, head_x, head_y, cur_dir); end
    n_vec++; if (step_cnt !== 16'd3) begin n_err++; $display("FAIL t2_cnt: got %0d expected 3", step_cnt); end
  endtask

  task automatic test_pause();
    repeat (2) tick();
    pause = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++; if ({step, head_x, head_y} !== {1'b0, 3'd6, 3'd3}) begin n_err++; $display("FAIL t4_frozen: step=%0b (%0d,%0d) expected 0 (6,3) cycle %0d", step, head_x, head_y, c); end
    end
    n_vec++; if (running !== 1'b1) begin n_err++; $display("FAIL t4_running: running=%0b expected 1 while paused", running); end
    pause = 1'b0;
    tick();
    n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL t4_early: step=1 expected 0"); end
    tick();
    n_vec++; if ({step, head_x, head_y, step_cnt} !== {1'b1, 3'd6, 3'd2, 16'd4}) begin n_err++; $display("FAIL t4_step: step=%0b (%0d,%0d) cnt %0d expected 1 (6,2) cnt 4", step, head_x, head_y, step_cnt); end
    tick();
    n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL t4_double: step=1 expected 0"); end
    // Pause exactly across the step edge: the step is deferred, not dropped.
    repeat (2) tick();
    pause = 1'b1;
    repeat (2) tick();
    n_vec++; if ({step, head_y} !== {1'b0, 3'd2}) begin n_err++; $display("FAIL t4_defer_hold: step=%0b y=%0d expected 0,2", step, head_y); end
    pause = 1'b0;
    tick();
    n_vec++; if ({step, head_x, head_y, step_cnt} !== {1'b1, 3'd6, 3'd1, 16'd5}) begin n_err++; $display("FAIL t4_deferred: step=%0b (%0d,%0d) cnt %0d expected 1 (6,1) cnt 5", step, head_x, head_y, step_cnt); end
  endtask

  task automatic test_reset_on_step();
    repeat (3) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    n_vec++; if ({step, running, game_over, cur_dir, head_x, head_y} !== 11'd0 || step_cnt !== 16'd0) begin n_err++; $display("FAIL t6_reset: step/run/over=%b (%0d,%0d) dir %b cnt %0d expected all 0", {step, running, game_over}, head_x, head_y, cur_dir, step_cnt); end
    rst = 1'b0;
    start = 1'b0;
    tick();
    n_vec++; if ({running, head_x, head_y} !== 7'd0) begin n_err++; $display("FAIL t6_idle: run=%0b (%0d,%0d) expected idle at (0,0)", running, head_x, head_y); end
  endtask

  initial begin
    test_reset();
    test_start_right_to_wall();
    test_restart_from_over();
    test_up_to_wall();
    test_reversal();
    test_pause();
    test_reset_on_step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
